scnn_layer_scheduler: RTL and testbench
=======================================

// Module: scnn_layer_scheduler
// PURPOSE
//  Top-level layer sequencer for the SCNN accelerator. Steps layer_count through the network and
//  drives the per-layer shape compiler. Per layer it handshakes weight load, then repeated
//  iact-load/PE-compute passes, then psum read-out. Sits between host start/done and the GLB/PE-array controllers.
// PARAMETERS
//  MAX_LAYERS   5   upper bound on total_layers; also the width of the layer-type LUT
//  LAYER_TYPE   5'b00011   bit i = 1 -> layer i is conv, 0 -> fc
// PORTS
//  clock                 in   1   system clock
//  reset                 in   1   synchronous, active-high
//  start                 in   1   one-cycle pulse; begins a network run when idle
//  total_layers          in   3   number of layers to run (0..MAX_LAYERS)
//  psum_acc_times_bound  in   8   iact/compute passes per layer (from shape compiler)
//  layer_count           out  3   current layer index; feeds shape compiler
//  conv_flag             out  1   LAYER_TYPE[layer_count]
//  weight_load_req       out  1   level request to GLB weight loader
//  weight_load_done      in   1   one-cycle completion pulse
//  iact_load_req         out  1   level request to GLB iact loader
//  iact_load_done        in   1   one-cycle completion pulse
//  pe_run_req            out  1   level request to PE array
//  pe_run_done           in   1   one-cycle completion pulse
//  psum_read_req         out  1   level request to psum read-out
//  psum_read_done        in   1   one-cycle completion pulse
//  psum_acc_times        out  8   passes completed in current layer
//  busy                  out  1   high from the cycle after start until DONE
//  done                  out  1   one-cycle pulse at end of network
// BEHAVIOUR
//  - Reset: state=IDLE; layer_count=0, psum_acc_times=0; all *_req, busy and done = 0.
//  - FSM states: IDLE, CFG, LOAD_W, LOAD_I, RUN, ACC, READ, NEXT, FIN.
//    IDLE -start-> CFG. If total_layers==0: IDLE -start-> FIN.
//    CFG:    1 cycle so the shape compiler outputs settle for the new layer_count -> LOAD_W.
//    LOAD_W: weight_load_req=1; on weight_load_done -> LOAD_I.
//    LOAD_I: iact_load_req=1; on iact_load_done -> RUN.
//    RUN:    pe_run_req=1; on pe_run_done -> ACC, and psum_acc_times += 1.
//    ACC:    if psum_acc_times >= max(bound,1) -> READ, else -> LOAD_I.
//    READ:   psum_read_req=1; on psum_read_done -> NEXT.
//    NEXT:   if layer_count == total_layers-1 -> FIN; else layer_count += 1,
//            psum_acc_times = 0, -> CFG.
//    FIN:    done=1 for exactly one cycle; layer_count and psum_acc_times cleared -> IDLE.
//  - Each *_req is a registered Moore output. It is high exactly while in its state and drops
//    the cycle after the matching *_done is sampled. At most one req is high in any cycle.
//  - A done pulse seen outside its matching state is ignored, with no state or counter change.
//    A done that arrives in the same cycle the req rises is accepted.
//  - start while busy is ignored. start and reset in the same cycle: reset wins.
//  - psum_acc_times_bound==0 is treated as 1 (one pass). The bound is sampled each time ACC is evaluated.
//  - total_layers > MAX_LAYERS is clamped to MAX_LAYERS.
//  - Reset mid-run: the FSM returns to IDLE next edge and all reqs drop. Downstream blocks are reset
//    by the same signal, so no outstanding-request cleanup is needed.
//  - Latency overhead per layer: CFG + ACC-per-pass + NEXT = 2 + N cycles beyond handshake time.
//  - busy: 1 in every state except IDLE. It goes low on the FIN->IDLE edge, coincident with done falling.
// STRUCTURE
//  - Shared package scnn_pkg: state encoding localparams, LAYER_TYPE default, MAX_LAYERS.
//  - Single module, no sub-modules. One FSM plus two counters (layer, acc-pass).
// TESTING
//  1. total_layers=2, bound=3, done responders with 2-cycle latency -> per layer: 1 weight, 3 iact,
//     3 run, 1 read handshake; layer_count goes 0,1; one done pulse; conv_flag=1 in both layers.
//  2. total_layers=5, bounds 12,6,15,4,1 -> conv_flag sequence 1,1,0,0,0; 38 total pe_run handshakes;
//     done once.
//  3. bound=0 -> exactly one LOAD_I/RUN pass per layer.
//  4. total_layers=0, start -> done pulse on the 2nd cycle, no req ever asserted.
//  5. Stray pe_run_done during LOAD_W, and start pulse mid-run -> both ignored; counters unchanged.
//  6. Reset asserted in RUN with pe_run_req high -> next cycle all outputs at reset values; a new
//     start runs cleanly from layer 0.

Source files
------------

// File: rtl/scnn_pkg.sv
// Shared definitions for the SCNN layer scheduler: FSM state encoding, network limits,
// the default layer-type map and small helpers used by the sequencer.
package scnn_pkg;

  localparam int MAX_LAYERS = 5;
  localparam int LAYER_W    = 3;
  localparam int ACC_W      = 8;

  // Bit i set -> layer i is a conv layer, clear -> fully connected.
  localparam logic [MAX_LAYERS-1:0] LAYER_TYPE_DEFAULT = 5'b00011;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG,
    ST_LOAD_W,
    ST_LOAD_I,
    ST_RUN,
    ST_ACC,
    ST_READ,
    ST_NEXT,
    ST_FIN
  } sched_state_t;

  function automatic logic [LAYER_W-1:0] clamp_layers(input logic [LAYER_W-1:0] n);
    if (n > LAYER_W'(MAX_LAYERS)) begin
      return LAYER_W'(MAX_LAYERS);
    end
    return n;
  endfunction

  // A zero pass bound still means one iact/compute pass.
  function automatic logic [ACC_W-1:0] eff_bound(input logic [ACC_W-1:0] b);
    return (b == '0) ? ACC_W'(1) : b;
  endfunction

endpackage

// File: rtl/scnn_layer_scheduler.sv
// Network-level layer sequencer: per layer a weight load, then iact-load/PE-run passes, then
// psum read-out; each step raises a registered level request and waits for its done pulse.
module scnn_layer_scheduler
  import scnn_pkg::*;
#(
  parameter logic [MAX_LAYERS-1:0] LAYER_TYPE = LAYER_TYPE_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [LAYER_W-1:0] total_layers,
  input  logic [ACC_W-1:0]   psum_acc_times_bound,
  output logic [LAYER_W-1:0] layer_count,
  output logic               conv_flag,
  output logic               weight_load_req,
  input  logic               weight_load_done,
  output logic               iact_load_req,
  input  logic               iact_load_done,
  output logic               pe_run_req,
  input  logic               pe_run_done,
  output logic               psum_read_req,
  input  logic               psum_read_done,
  output logic [ACC_W-1:0]   psum_acc_times,
  output logic               busy,
  output logic               done
);

  sched_state_t       r_state;
  sched_state_t       w_next_state;
  logic [LAYER_W-1:0] r_layer;
  logic [LAYER_W-1:0] r_total;
  logic [ACC_W-1:0]   r_acc;
  logic               r_weight_load_req;
  logic               r_iact_load_req;
  logic               r_pe_run_req;
  logic               r_psum_read_req;
  logic               r_busy;
  logic               r_done;
  logic               w_last_layer;
  logic               w_pass_done;

  assign w_last_layer = (r_layer == r_total - LAYER_W'(1));
  // The bound is read live so the shape compiler may update it between passes.
  assign w_pass_done  = (r_acc >= eff_bound(psum_acc_times_bound));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (total_layers == '0) ? ST_FIN : ST_CFG;
        end
      end
      ST_CFG:    w_next_state = ST_LOAD_W;
      ST_LOAD_W: if (weight_load_done) w_next_state = ST_LOAD_I;
      ST_LOAD_I: if (iact_load_done)   w_next_state = ST_RUN;
      ST_RUN:    if (pe_run_done)      w_next_state = ST_ACC;
      ST_ACC:    w_next_state = w_pass_done ? ST_READ : ST_LOAD_I;
      ST_READ:   if (psum_read_done)   w_next_state = ST_NEXT;
      ST_NEXT:   w_next_state = w_last_layer ? ST_FIN : ST_CFG;
      ST_FIN:    w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so each request is a flop that tracks its state exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_weight_load_req <= 1'b0;
      r_iact_load_req   <= 1'b0;
      r_pe_run_req      <= 1'b0;
      r_psum_read_req   <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
    end else begin
      r_weight_load_req <= (w_next_state == ST_LOAD_W);
      r_iact_load_req   <= (w_next_state == ST_LOAD_I);
      r_pe_run_req      <= (w_next_state == ST_RUN);
      r_psum_read_req   <= (w_next_state == ST_READ);
      r_busy            <= (w_next_state != ST_IDLE);
      r_done            <= (w_next_state == ST_FIN);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_layer <= '0;
      r_acc   <= '0;
      r_total <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_total <= clamp_layers(total_layers);
          end
        end
        ST_RUN: begin
          if (pe_run_done) begin
            r_acc <= r_acc + ACC_W'(1);
          end
        end
        ST_NEXT: begin
          if (!w_last_layer) begin
            r_layer <= r_layer + LAYER_W'(1);
            r_acc   <= '0;
          end
        end
        ST_FIN: begin
          r_layer <= '0;
          r_acc   <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign layer_count     = r_layer;
  assign psum_acc_times  = r_acc;
  assign conv_flag       = LAYER_TYPE[r_layer];
  assign weight_load_req = r_weight_load_req;
  assign iact_load_req   = r_iact_load_req;
  assign pe_run_req      = r_pe_run_req;
  assign psum_read_req   = r_psum_read_req;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_scnn_layer_scheduler.sv
// Directed bench for scnn_layer_scheduler: latency-programmable done responders, a handshake-level
// expectation model, and per-cycle protocol invariants.
module tb_scnn_layer_scheduler;

  localparam logic [4:0] LT_MODEL = 5'b00011;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_main = 1'b0;
  logic       start_stray = 1'b0;
  logic       start;
  logic [2:0] total_layers = '0;
  logic [7:0] psum_acc_times_bound;
  logic [2:0] layer_count;
  logic       conv_flag;
  logic       weight_load_req, iact_load_req, pe_run_req, psum_read_req;
  logic       weight_load_done, iact_load_done, pe_run_done, psum_read_done;
  logic [7:0] psum_acc_times;
  logic       busy, done;

  logic       rw_done = 1'b0, ri_done = 1'b0, rp_done = 1'b0, rr_done = 1'b0;
  logic       stray_pe = 1'b0;
  logic [7:0] bound_tab [8] = '{default: 8'd0};
  int         lat = 1;

  assign start                = start_main | start_stray;
  assign weight_load_done     = rw_done;
  assign iact_load_done       = ri_done;
  assign pe_run_done          = rp_done | stray_pe;
  assign psum_read_done       = rr_done;
  assign psum_acc_times_bound = bound_tab[layer_count];

  scnn_layer_scheduler dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .total_layers        (total_layers),
    .psum_acc_times_bound(psum_acc_times_bound),
    .layer_count         (layer_count),
    .conv_flag           (conv_flag),
    .weight_load_req     (weight_load_req),
    .weight_load_done    (weight_load_done),
    .iact_load_req       (iact_load_req),
    .iact_load_done      (iact_load_done),
    .pe_run_req          (pe_run_req),
    .pe_run_done         (pe_run_done),
    .psum_read_req       (psum_read_req),
    .psum_read_done      (psum_read_done),
    .psum_acc_times      (psum_acc_times),
    .busy                (busy),
    .done                (done)
  );

  always #5 clock = ~clock;

  // Responder: answers whichever request is high after it has been high for 'lat' cycles.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      rw_done = 1'b0; ri_done = 1'b0; rp_done = 1'b0; rr_done = 1'b0;
      if (weight_load_req | iact_load_req | pe_run_req | psum_read_req) begin
        cnt++;
        if (cnt >= lat) begin
          rw_done = weight_load_req;
          ri_done = iact_load_req;
          rp_done = pe_run_req;
          rr_done = psum_read_req;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  typedef struct {
    int kind;   // 0 weight, 1 iact, 2 pe run, 3 psum read
    int layer;
    int acc;
    bit conv;
  } hs_t;

  hs_t log_q[$];
  int  checks = 0;
  int  failures = 0;
  int  done_cnt = 0;
  int  cur_total = 0;
  bit  chk_en = 1'b0;
  bit  sim_done = 1'b0;

  task automatic check_eq(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit req_of(input int k);
    case (k)
      0:       return weight_load_req;
      1:       return iact_load_req;
      2:       return pe_run_req;
      3:       return psum_read_req;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint enc(input hs_t h);
    return longint'(h.kind) * 1000000 + longint'(h.layer) * 10000 + longint'(h.acc) * 10 + longint'(h.conv);
  endfunction

  // Runs one network and checks timing, handshake sequence and done behaviour against the model.
  task automatic run_case(input string nm, input int n, input int latv,
                          input int lit_off, input int lit_runs, input int lit_conv);
    hs_t        exp_q[$];
    hs_t        h;
    int         base, off, exp_off, d0, nl, b, runs, got_n;
    logic [4:0] conv_bits;
    @(negedge clock);
    lat          = latv;
    total_layers = 3'(n);
    nl           = (n > 5) ? 5 : n;
    cur_total    = nl;
    exp_off      = 0;
    for (int l = 0; l < nl; l++) begin
      b = (bound_tab[l] == 8'd0) ? 1 : int'(bound_tab[l]);
      exp_q.push_back('{0, l, 0, LT_MODEL[l]});
      for (int p = 0; p < b; p++) begin
        exp_q.push_back('{1, l, p, LT_MODEL[l]});
        exp_q.push_back('{2, l, p, LT_MODEL[l]});
      end
      exp_q.push_back('{3, l, b, LT_MODEL[l]});
      exp_off += 2 + 2 * latv + b * (2 * latv + 1);
    end
    base = log_q.size();
    d0   = done_cnt;
    start_main = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_main = 1'b0;
    off = 0;
    while (done !== 1'b1 && off < 5000) begin
      @(negedge clock);
      off++;
    end
    check_eq({nm, "_done_offset"}, off, exp_off);
    if (lit_off >= 0) check_eq({nm, "_done_offset_literal"}, off, lit_off);
    @(negedge clock);
    check_eq({nm, "_done_busy_fall"}, {done, busy}, 0);
    repeat (3) @(negedge clock);
    check_eq({nm, "_done_pulses"}, done_cnt - d0, 1);
    check_eq({nm, "_idle_after"}, {busy, weight_load_req, iact_load_req, pe_run_req, psum_read_req}, 0);
    got_n = log_q.size() - base;
    check_eq({nm, "_handshake_count"}, got_n, exp_q.size());
    runs      = 0;
    conv_bits = '0;
    for (int i = 0; i < got_n; i++) begin
      h = log_q[base + i];
      if (i < exp_q.size()) check_eq($sformatf("%s_hs%0d", nm, i), enc(h), enc(exp_q[i]));
      if (h.kind == 2) runs++;
      if (h.kind == 0 && h.layer < 5) conv_bits[h.layer] = h.conv;
    end
    if (lit_runs >= 0) check_eq({nm, "_pe_runs_literal"}, runs, lit_runs);
    if (lit_conv >= 0) check_eq({nm, "_conv_flags_literal"}, conv_bits, lit_conv);
  endtask

  task automatic stray_inject();
    int w;
    w = 0;
    while (weight_load_req !== 1'b1 && w < 200) begin
      @(negedge clock);
      w++;
    end
    check_eq("stray_reached_load_w", weight_load_req, 1);
    stray_pe    = 1'b1;
    start_stray = 1'b1;
    @(negedge clock);
    stray_pe    = 1'b0;
    start_stray = 1'b0;
    check_eq("stray_ignored", {weight_load_req, busy, layer_count, psum_acc_times}, {1'b1, 1'b1, 3'd0, 8'd0});
  endtask

  initial begin
    fork
      begin : main_seq
        int w;
        repeat (3) @(negedge clock);
        check_eq("reset_state", {layer_count, psum_acc_times, weight_load_req, iact_load_req,
                                 pe_run_req, psum_read_req, busy, done}, 0);
        check_eq("reset_conv_flag", conv_flag, 1);
        reset  = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 8; i++) bound_tab[i] = 8'd3;
        run_case("t1_two_layers", 2, 2, 42, 6, 3);

        bound_tab[0] = 8'd12; bound_tab[1] = 8'd6; bound_tab[2] = 8'd15;
        bound_tab[3] = 8'd4;  bound_tab[4] = 8'd1;
        run_case("t2_five_layers", 5, 1, 134, 38, 5'b00011);

        for (int i = 0; i < 8; i++) bound_tab[i] = 8'd0;
        run_case("t3_zero_bound", 2, 1, 14, 2, 3);

        run_case("t4_zero_layers", 0, 1, 0, 0, -1);

        bound_tab[0] = 8'd2;
        fork
          run_case("t5_stray", 1, 3, 22, 2, 1);
          stray_inject();
        join

        for (int i = 0; i < 8; i++) bound_tab[i] = 8'd3;
        @(negedge clock);
        lat = 2; total_layers = 3'd2; cur_total = 2;
        start_main = 1'b1;
        @(negedge clock);
        start_main = 1'b0;
        w = 0;
        while (pe_run_req !== 1'b1 && w < 200) begin
          @(negedge clock);
          w++;
        end
        check_eq("t6_reached_run", pe_run_req, 1);
        reset = 1'b1;
        start_main = 1'b1;
        @(negedge clock);
        check_eq("t6_reset_outputs", {layer_count, psum_acc_times, weight_load_req, iact_load_req,
                                      pe_run_req, psum_read_req, busy, done}, 0);
        reset = 1'b0;
        start_main = 1'b0;
        @(negedge clock);
        check_eq("t6_stays_idle", {busy, done, weight_load_req, iact_load_req, pe_run_req, psum_read_req}, 0);
        run_case("t6_rerun", 2, 2, 42, 6, 3);

        for (int i = 0; i < 8; i++) bound_tab[i] = 8'd1;
        run_case("t7_clamp", 7, 1, 35, 5, 5'b00011);

        sim_done = 1'b1;
      end
      begin : per_cycle
        int         nreq, prev_kind, bb;
        logic [5:0] viol;
        prev_kind = -1;
        while (!sim_done) begin
          @(negedge clock);
          if (chk_en && !reset) begin
            nreq = int'(weight_load_req) + int'(iact_load_req) + int'(pe_run_req) + int'(psum_read_req);
            bb   = (bound_tab[layer_count] == 8'd0) ? 1 : int'(bound_tab[layer_count]);
            viol = '0;
            if (nreq > 1) viol[0] = 1'b1;
            if (conv_flag !== LT_MODEL[layer_count]) viol[1] = 1'b1;
            if (done && !busy) viol[2] = 1'b1;
            if (!busy && (nreq != 0 || layer_count != 3'd0 || psum_acc_times != 8'd0)) viol[3] = 1'b1;
            if (busy && int'(layer_count) >= ((cur_total == 0) ? 1 : cur_total)) viol[4] = 1'b1;
            if (int'(psum_acc_times) > bb) viol[5] = 1'b1;
            check_eq("cycle_invariants", viol, 0);
            if (prev_kind >= 0) check_eq($sformatf("req%0d_drop_after_done", prev_kind), req_of(prev_kind), 0);
            prev_kind = -1;
            if (done) done_cnt++;
            if (weight_load_req && weight_load_done) begin
              log_q.push_back('{0, int'(layer_count), int'(psum_acc_times), conv_flag});
              prev_kind = 0;
            end
            if (iact_load_req && iact_load_done) begin
              log_q.push_back('{1, int'(layer_count), int'(psum_acc_times), conv_flag});
              prev_kind = 1;
            end
            if (pe_run_req && pe_run_done) begin
              log_q.push_back('{2, int'(layer_count), int'(psum_acc_times), conv_flag});
              prev_kind = 2;
            end
            if (psum_read_req && psum_read_done) begin
              log_q.push_back('{3, int'(layer_count), int'(psum_acc_times), conv_flag});
              prev_kind = 3;
            end
          end else begin
            prev_kind = -1;
          end
        end
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
